// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: parses a length-prefixed byte stream,
// writes little-endian 32-bit words, verifies an XOR checksum and gates the core.
module imem_loader #(
    parameter int ROM_SIZE = 512,
    parameter int ADDR_W   = $clog2(ROM_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_CSUM = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic              accept;
    logic [31:0]       len_full;
    logic [ADDR_W:0]   idx_inc;

    assign in_ready  = (state_q != S_DONE);
    assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign core_hold = (state_q != S_DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[31:8]};
    assign idx_inc  = idx_q + (ADDR_W+1)'(1);

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d      = len_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_full > 32'(ROM_SIZE)) begin
                            state_d = S_ERR;
                        end else if (len_full == 32'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[ADDR_W-1:0];
                        wr_data_d = {in_data, word_q};
                        idx_d     = idx_inc;
                        if (32'(idx_inc) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        word_d = {in_data, word_q[23:8]};
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                // start takes priority; any byte accepted in ERR is simply dropped
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    word_d     = '0;
                    idx_d      = '0;
                    csum_d     = '0;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a stream-level
// model: expected writes and final status are derived from the load's word list.
module tb_imem_loader;

    localparam int ROM_SIZE = 512;
    localparam int ADDR_W   = $clog2(ROM_SIZE);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              start = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;

    int          vectors = 0;
    int          miscompares = 0;
    int          dbl_wr = 0;
    logic        prev_wr = 1'b0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] words[$];

    imem_loader #(.ROM_SIZE(ROM_SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and flag any strobe lasting two cycles
    always @(negedge clk) begin
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            if (prev_wr) dbl_wr++;
        end
        prev_wr = wr_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output decode derived from the load outcome: loading, finished good, finished bad
    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        check({tag, " done"},      32'(done),      32'(exp_done));
        check({tag, " error"},     32'(error),     32'(exp_err));
        check({tag, " busy"},      32'(busy),      32'(!exp_done && !exp_err));
        check({tag, " in_ready"},  32'(in_ready),  32'(!exp_done));
        check({tag, " core_hold"}, 32'(core_hold), 32'(!exp_done));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " wr_en"},   32'(wr_en),   32'd0);
        check({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, " wr_data"}, wr_data,      32'd0);
        check_status(tag, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(3, 0));
    endfunction

    task automatic compare_writes(input string tag);
        int n;
        check({tag, " write count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
        end
        check({tag, " single-cycle wr_en"}, dbl_wr, 0);
    endtask

    // Sends a whole load of n words taken from words[], then checks writes and outcome
    task automatic run_load(input string tag, input logic [31:0] n, input bit bad, input int gap_mode);
        logic [7:0]  csum;
        logic [31:0] w;
        obs_q.delete();
        exp_q.delete();
        dbl_wr = 0;
        csum   = 8'h00;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], pick_gap(gap_mode));
        if (n > 32'(ROM_SIZE)) begin
            for (int k = 0; k < 6; k++) send_byte(8'($urandom), pick_gap(gap_mode));
            idle(3);
            compare_writes(tag);
            check_status(tag, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = words[i];
                for (int k = 0; k < 4; k++) begin
                    csum ^= w[8*k +: 8];
                    send_byte(w[8*k +: 8], pick_gap(gap_mode));
                end
                exp_q.push_back({ADDR_W'(i), w});
            end
            send_byte(csum ^ (bad ? 8'h01 : 8'h00), pick_gap(gap_mode));
            idle(3);
            compare_writes(tag);
            check_status(tag, !bad, bad);
        end
    endtask

    initial begin
        logic [31:0] n_rand;

        // Reset before any clock edge proves it is asynchronous
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        words = '{32'h0000_0013, 32'h00A0_0093};
        run_load("n2", 32'd2, 1'b0, 0);
        pulse_start();
        check_status("n2 restart", 1'b0, 1'b0);

        run_load("n0 good", 32'd0, 1'b0, 0);
        pulse_start();
        run_load("n0 bad", 32'd0, 1'b1, 0);
        pulse_start();
        check_status("n0 restart", 1'b0, 1'b0);

        run_load("n513", 32'd513, 1'b0, 0);

        // start and a byte together in ERR: start wins and the byte is dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h05;
        start    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check_status("err start", 1'b0, 1'b0);
        run_load("after err start", 32'd0, 1'b0, 0);
        pulse_start();

        words = '{32'h0000_0013, 32'h00A0_0093};
        run_load("n2 toggle", 32'd2, 1'b0, 1);
        pulse_start();
        run_load("n2 gaps", 32'd2, 1'b0, 2);
        pulse_start();

        for (int r = 0; r < 4; r++) begin
            n_rand = 32'($urandom_range(8, 1));
            words.delete();
            for (int i = 0; i < int'(n_rand); i++) words.push_back($urandom);
            run_load($sformatf("rand%0d", r), n_rand, (r == 2), 2);
            pulse_start();
        end

        // start during DATA is ignored, then a reset abandons the load mid-word
        obs_q.delete();
        dbl_wr = 0;
        send_byte(8'h02, 0);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k), 0);
        pulse_start();
        check_status("start in data", 1'b0, 1'b0);
        send_byte(8'hA3, 0);
        send_byte(8'hB0, 0);
        idle(2);
        #2 rst = 1'b1;
        #1 check_reset_values("mid reset");
        check("mid reset writes", obs_q.size(), 1);
        if (obs_q.size() > 0) check("mid reset data", obs_q[0].data, 32'hA3A2_A1A0);
        @(negedge clk);
        rst = 1'b0;
        words = '{32'hDEAD_BEEF};
        run_load("n1 after reset", 32'd1, 1'b0, 0);
        pulse_start();

        words.delete();
        for (int i = 0; i < ROM_SIZE; i++) words.push_back(32'(i) * 32'h0001_0001 + 32'h100);
        run_load("full rom", 32'(ROM_SIZE), 1'b0, 0);
        if (obs_q.size() > 0)
            check("full rom last addr", 32'(obs_q[obs_q.size()-1].addr), 32'(ROM_SIZE - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
